// File: rtl/forward_hazard_unit.sv
// forward_hazard_unit: EX operand forwarding selects plus load-use stall / branch flush pipeline control
// Ports: clk, rst (sync, active-high), enable (pipeline advance); ID sources id_rs/id_rt with use flags;
// EX producer ex_regwrite/ex_memread/ex_rd; MEM producer mem_regwrite/mem_rd; branch_taken (resolved in MEM);
// registered forward_a_sel/forward_b_sel (00 regfile, 10 EX/MEM, 01 MEM/WB); combinational pc_enable,
// ifid_enable, idex_bubble, ifid_flush, exmem_flush; stall_count counts load-use stall cycles (saturating).
module forward_hazard_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rs,
    input  logic        id_uses_rt,
    input  logic        ex_regwrite,
    input  logic        ex_memread,
    input  logic [4:0]  ex_rd,
    input  logic        mem_regwrite,
    input  logic [4:0]  mem_rd,
    input  logic        branch_taken,
    output logic [1:0]  forward_a_sel,
    output logic [1:0]  forward_b_sel,
    output logic        pc_enable,
    output logic        ifid_enable,
    output logic        idex_bubble,
    output logic        ifid_flush,
    output logic        exmem_flush,
    output logic [15:0] stall_count
);
    typedef enum logic [1:0] {RUN, LSTALL, FLUSH} state_t;
    state_t      state_q, state_d;
    logic [1:0]  forward_a_sel_q, forward_a_sel_d;
    logic [1:0]  forward_b_sel_q, forward_b_sel_d;
    logic [15:0] stall_count_q, stall_count_d;
    logic        act, load_use, flush, stall;
    function automatic logic [1:0] fwd_sel(input logic uses, input logic [4:0] r);
        return (uses && r != 5'd0 && ex_regwrite && ex_rd == r) ? 2'b10 :
               (uses && r != 5'd0 && mem_regwrite && mem_rd == r) ? 2'b01 : 2'b00;
    endfunction
    always_comb begin
        act      = enable && !rst;
        load_use = ex_memread && ex_rd != 5'd0 &&
                   ((id_uses_rs && id_rs == ex_rd) || (id_uses_rt && id_rt == ex_rd));
        flush    = act && branch_taken;
        // LSTALL is the cycle after the stall; the bubble now sits in EX so the hazard cannot recur
        stall    = act && !branch_taken && load_use && state_q == RUN;
        state_d  = !enable ? state_q : flush ? FLUSH : stall ? LSTALL : RUN;
        // A bubble enters EX on stall or flush, so it must not forward anything
        forward_a_sel_d = !enable ? forward_a_sel_q : (flush || stall) ? 2'b00 : fwd_sel(id_uses_rs, id_rs);
        forward_b_sel_d = !enable ? forward_b_sel_q : (flush || stall) ? 2'b00 : fwd_sel(id_uses_rt, id_rt);
        stall_count_d   = (stall && stall_count_q != 16'hFFFF) ? stall_count_q + 16'd1 : stall_count_q;
        pc_enable   = act && !stall;
        ifid_enable = act && !stall;
        idex_bubble = flush || stall;
        ifid_flush  = flush;
        exmem_flush = flush;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= RUN;
            forward_a_sel_q <= 2'b00;
            forward_b_sel_q <= 2'b00;
            stall_count_q   <= 16'd0;
        end else begin
            state_q         <= state_d;
            forward_a_sel_q <= forward_a_sel_d;
            forward_b_sel_q <= forward_b_sel_d;
            stall_count_q   <= stall_count_d;
        end
    end
    assign forward_a_sel = forward_a_sel_q;
    assign forward_b_sel = forward_b_sel_q;
    assign stall_count   = stall_count_q;
endmodule

// File: doc/forward_hazard_unit.md
FORWARD_HAZARD_UNIT -- requirements
Module: forward_hazard_unit

Interface
REQ-001 The block SHALL have ports clk (input, 1, sole clock; all state updates on its rising edge) and rst (input, 1, synchronous, active-high reset).
REQ-002 The block SHALL have port enable (input, 1): global pipeline advance; 0 freezes all state and registered outputs.
REQ-003 The block SHALL have ports id_rs and id_rt (input, 5 each): source register numbers of the instruction in ID.
REQ-004 The block SHALL have ports id_uses_rs and id_uses_rt (input, 1 each): the ID instruction actually reads rs / rt.
REQ-005 The block SHALL have ports ex_regwrite, ex_memread (input, 1 each) and ex_rd (input, 5): destination info of the instruction in EX.
REQ-006 The block SHALL have ports mem_regwrite (input, 1) and mem_rd (input, 5): destination info of the instruction in MEM.
REQ-007 The block SHALL have port branch_taken (input, 1): branch resolved taken in MEM.
REQ-008 The block SHALL have ports forward_a_sel and forward_b_sel (output, 2 each, registered): EX operand-A / operand-B source select.
REQ-009 The block SHALL have ports pc_enable and ifid_enable (output, 1 each): PC and IF/ID register advance.
REQ-010 The block SHALL have ports idex_bubble, ifid_flush and exmem_flush (output, 1 each): insert NOP into ID/EX; clear IF/ID; clear EX/MEM control.
REQ-011 The block SHALL have port stall_count (output, 16): number of load-use stall cycles since reset.

Function
REQ-012 Select encoding SHALL be: 00 = register-file data, 10 = EX/MEM ALU result, 01 = MEM/WB write-back data; 11 SHALL never be driven.
REQ-013 The selects SHALL be computed in ID and registered, so they are valid in the cycle the instruction occupies EX.
REQ-014 For operand A, when id_uses_rs=1, id_rs!=0, ex_regwrite=1 and ex_rd==id_rs, the next forward_a_sel SHALL be 10.
REQ-015 Otherwise, when id_uses_rs=1, id_rs!=0, mem_regwrite=1 and mem_rd==id_rs, the next forward_a_sel SHALL be 01; in all remaining cases it SHALL be 00.
REQ-016 Operand B SHALL follow REQ-014/015 identically, using id_uses_rt and id_rt.
REQ-017 Register 0 SHALL never be forwarded, and the EX-stage producer SHALL take priority over the MEM-stage producer.
REQ-018 A load-use hazard SHALL be detected when ex_memread=1, ex_rd!=0, and ex_rd matches id_rs (with id_uses_rs=1) or id_rt (with id_uses_rt=1).
REQ-019 FSM states SHALL be RUN, LSTALL and FLUSH.
REQ-020 RUN: pc_enable=1, ifid_enable=1, and all flush/bubble outputs 0.
REQ-021 RUN to LSTALL SHALL occur on a load-use hazard.
REQ-022 LSTALL SHALL last exactly one cycle: pc_enable=0, ifid_enable=0, idex_bubble=1, and stall_count incremented (saturating at 16'hFFFF); its exit is RUN.
REQ-023 The registered selects SHALL be 00 during a bubble cycle; on the following cycle the load is in MEM and REQ-015 yields 01.
REQ-024 Any state SHALL go to FLUSH on branch_taken=1.
REQ-025 FLUSH SHALL last one cycle: ifid_flush=1, idex_bubble=1, exmem_flush=1, pc_enable=1 (PC loads the target), selects 00; its exit is RUN.
REQ-026 branch_taken and a load-use hazard in the same cycle SHALL select FLUSH, with no stall_count increment.
REQ-027 branch_taken during FLUSH SHALL re-enter FLUSH.
REQ-028 The control outputs in REQ-020/022/025 SHALL be decoded combinationally from the state register and the current hazard/branch inputs, so the stall or flush takes effect in the detection cycle.
REQ-029 With enable=0, state, selects and stall_count SHALL hold; pc_enable and ifid_enable SHALL be 0; flush/bubble outputs SHALL be 0.

Reset
REQ-030 While rst=1 (sampled at clk edge): state=RUN, forward_a_sel=forward_b_sel=00, stall_count=0.
REQ-031 While rst=1, combinational outputs SHALL be pc_enable=0, ifid_enable=0, idex_bubble=0, ifid_flush=0, exmem_flush=0.
REQ-032 rst SHALL override enable and branch_taken; reset asserted during LSTALL or FLUSH SHALL abort to RUN with no stall_count increment.

Verification
REQ-033 ex_regwrite=1, ex_rd=5, id_rs=5, id_uses_rs=1 -> next cycle forward_a_sel=10, forward_b_sel=00.
REQ-034 ex_rd=5 and mem_rd=5, both regwrite, id_rt=5, id_uses_rt=1 -> forward_b_sel=10; with ex_regwrite=0 -> 01; with id_rt=0 and all rd=0 -> 00.
REQ-035 ex_memread=1, ex_rd=8, id_rt=8 -> that cycle pc_enable=0, idex_bubble=1; next cycle selects 00, stall_count=1; then with mem_rd=8 -> forward_b_sel=01.
REQ-036 branch_taken=1 together with a load-use hazard -> FLUSH outputs asserted one cycle, stall_count unchanged, RUN next.
REQ-037 enable=0 for 3 cycles during LSTALL -> state, selects and stall_count frozen; resumes correctly when enable=1.
REQ-038 rst=1 while in FLUSH with stall_count=3 -> next cycle state=RUN, stall_count=0, selects 00.
